// File: rtl/bus_rr_arbiter_if.sv
// Bus arbitration interface between the four masters and the round-robin arbiter.
//   req       : per-master request, bit i belongs to master i
//   grant     : registered one-hot grant, all-zero when idle
//   grant_idx : binary index of the current owner (valid while bus_busy=1)
//   bus_busy  : any grant bit set
//   preempt   : one-cycle pulse on the first cycle of a forced-rotation grant
// Modports: master (request side), slave (arbiter side).
interface bus_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       bus_busy;
  logic       preempt;

  modport master (output req, input grant, input grant_idx, input bus_busy, input preempt);
  modport slave  (input req, output grant, output grant_idx, output bus_busy, output preempt);
endinterface

// File: rtl/bus_rr_arbiter.sv
// Four-master round-robin bus arbiter with registered one-hot grants.
// Ports:
//   clk     : bus clock, rising-edge active
//   reset_n : asynchronous active-low reset
//   bus     : bus_rr_arbiter_if.slave (req in; grant, grant_idx, bus_busy, preempt out)
// Parameter MAX_HOLD (2..255): longest grant while another master waits.
// Optional macro BUS_ARB_HOLD_LIMIT_EN enables the hold-limit timer and the
// preempt pulse; without it an owner keeps the bus until its req drops and
// preempt is tied low.
module bus_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  bus_rr_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  // Elaboration-time guard on the hold-limit range.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_rr_arbiter: MAX_HOLD must be within 2..255");
  end

  logic [0:0] state, state_nxt;
  logic [3:0] grant_q, grant_nxt;
  logic [1:0] idx_q, idx_nxt;
  logic [1:0] prio_ptr, ptr_nxt;
  logic       busy_q, busy_nxt;
  logic [3:0] search_mask;
  logic       found;
  logic [1:0] cand;
  logic       take;

`ifdef BUS_ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt, hold_nxt;
  logic       preempt_q, preempt_nxt;
`endif

  // First set bit of mask, scanning from ptr+1 and wrapping mod 4.
  function automatic logic [2:0] pick(input logic [3:0] mask, input logic [1:0] ptr);
    logic       hit;
    logic [1:0] sel;
    logic [1:0] idx;
    hit = 1'b0;
    sel = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (mask[idx] && !hit) begin
        hit = 1'b1;
        sel = idx;
      end
    end
    return {hit, sel};
  endfunction

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      grant_q  <= 4'd0;
      idx_q    <= 2'd0;
      prio_ptr <= 2'd3;
      busy_q   <= 1'b0;
`ifdef BUS_ARB_HOLD_LIMIT_EN
      hold_cnt  <= 8'd0;
      preempt_q <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      grant_q  <= grant_nxt;
      idx_q    <= idx_nxt;
      prio_ptr <= ptr_nxt;
      busy_q   <= busy_nxt;
`ifdef BUS_ARB_HOLD_LIMIT_EN
      hold_cnt  <= hold_nxt;
      preempt_q <= preempt_nxt;
`endif
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    idx_nxt   = idx_q;
    ptr_nxt   = prio_ptr;
    busy_nxt  = busy_q;
    take      = 1'b0;
`ifdef BUS_ARB_HOLD_LIMIT_EN
    hold_nxt    = hold_cnt;
    preempt_nxt = 1'b0;
`endif
    // While owning, the owner is excluded; prio_ptr equals the owner, so it
    // would otherwise be found last anyway.
    search_mask   = (state == OWN) ? (bus.req & ~grant_q) : bus.req;
    {found, cand} = pick(search_mask, prio_ptr);

    case (state)
      IDLE: begin
        if (found) take = 1'b1;
      end
      OWN: begin
        if (!bus.req[idx_q]) begin
          if (found) begin
            take = 1'b1;
          end else begin
            state_nxt = IDLE;
            grant_nxt = 4'd0;
            busy_nxt  = 1'b0;
          end
        end
`ifdef BUS_ARB_HOLD_LIMIT_EN
        else if (found && hold_cnt == HOLD_LAST) begin
          take        = 1'b1;
          preempt_nxt = 1'b1;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_nxt = hold_cnt + 8'd1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase

    if (take) begin
      state_nxt = OWN;
      grant_nxt = 4'b0001 << cand;
      idx_nxt   = cand;
      ptr_nxt   = cand;
      busy_nxt  = 1'b1;
`ifdef BUS_ARB_HOLD_LIMIT_EN
      hold_nxt  = 8'd0;
`endif
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_idx = idx_q;
  assign bus.bus_busy  = busy_q;
`ifdef BUS_ARB_HOLD_LIMIT_EN
  assign bus.preempt   = preempt_q;
`else
  assign bus.preempt   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: a cycle model pushes expected
// outputs into a queue as each request vector is driven; entries are popped
// and compared one edge later. Directed checks cover reset and handoff cases.
module tb_bus_rr_arbiter;

  localparam int MAXH = 4;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] idx;
    logic       busy;
    logic       pre;
  } exp_t;

  logic clk;
  logic reset_n;
  bus_rr_arbiter_if bus ();

  bus_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  // Model state.
  bit m_busy;
  int m_owner;
  int m_idx;
  int m_ptr;
  int m_hold;
  bit m_pre;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_idx = 0; m_ptr = 3; m_hold = 0; m_pre = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_step(input logic [3:0] r);
    int nxt;
    bit give;
    nxt  = -1;
    give = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (nxt < 0 && r[c] && !(m_busy && c == m_owner)) nxt = c;
    end
    m_pre = 1'b0;
    if (!m_busy) begin
      give = (nxt >= 0);
    end else if (!r[m_owner]) begin
      if (nxt >= 0) give = 1'b1;
      else m_busy = 1'b0;
    end else begin
`ifdef BUS_ARB_HOLD_LIMIT_EN
      if (m_hold == MAXH - 1 && nxt >= 0) begin
        give  = 1'b1;
        m_pre = 1'b1;
      end else if (m_hold < MAXH - 1) begin
        m_hold++;
      end
`endif
    end
    if (give) begin
      m_busy = 1'b1; m_owner = nxt; m_idx = nxt; m_ptr = nxt; m_hold = 0;
    end
  endtask

  // Drive req now, predict, then compare just after the next rising edge.
  task automatic apply(input logic [3:0] r);
    exp_t e, g;
    bus.req = r;
    model_step(r);
    e.grant = m_busy ? (4'b0001 << m_idx) : 4'b0000;
    e.idx   = 2'(m_idx);
    e.busy  = m_busy;
    e.pre   = m_pre;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 8'd1, 8'd0);
    end else begin
      e = sb_q.pop_front();
      g.grant = bus.grant; g.idx = bus.grant_idx; g.busy = bus.bus_busy; g.pre = bus.preempt;
      chk("sb_grant",   8'(g.grant), 8'(e.grant));
      chk("sb_busy",    8'(g.busy),  8'(e.busy));
      chk("sb_preempt", 8'(g.pre),   8'(e.pre));
      if (e.busy) chk("sb_idx", 8'(g.idx), 8'(e.idx));
    end
  endtask

  task automatic cycle(input logic [3:0] r);
    @(negedge clk);
    apply(r);
  endtask

  task automatic full_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.req = 4'b0000;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    reset_n = 1'b0;
    bus.req = 4'b1111;
    model_reset();

    // Reset with every master requesting.
    repeat (3) @(negedge clk);
    chk("rst_grant",   8'(bus.grant),     8'h0);
    chk("rst_busy",    8'(bus.bus_busy),  8'h0);
    chk("rst_idx",     8'(bus.grant_idx), 8'h0);
    chk("rst_preempt", 8'(bus.preempt),   8'h0);
    @(negedge clk);
    reset_n = 1'b1;
    apply(4'b1111);
    chk("post_rst_grant", 8'(bus.grant), 8'h01);
    cycle(4'b0000);
    chk("release_idle", 8'(bus.grant), 8'h00);

    // Single request; grant_idx holds after release.
    cycle(4'b0100);
    chk("single_grant", 8'(bus.grant),     8'h04);
    chk("single_idx",   8'(bus.grant_idx), 8'h02);
    chk("single_busy",  8'(bus.bus_busy),  8'h01);
    cycle(4'b0000);
    chk("single_drop", 8'(bus.grant),     8'h00);
    chk("idx_hold",    8'(bus.grant_idx), 8'h02);

    // Zero-gap handoff 0 -> 1 -> 2.
    cycle(4'b0001);
    chk("own0", 8'(bus.grant), 8'h01);
    cycle(4'b0110);
    chk("handoff_1", 8'(bus.grant), 8'h02);
    cycle(4'b0100);
    chk("handoff_2", 8'(bus.grant), 8'h04);
    cycle(4'b0000);

    // Wraparound 3 -> 0.
    cycle(4'b1000);
    chk("own3", 8'(bus.grant), 8'h08);
    cycle(4'b0011);
    chk("wrap_grant", 8'(bus.grant),     8'h01);
    chk("wrap_idx",   8'(bus.grant_idx), 8'h00);
    cycle(4'b0000);

    // Hold limit with all masters requesting constantly.
    full_reset();
    for (int i = 0; i < 40; i++) begin
      logic [3:0] eg;
      logic       ep;
`ifdef BUS_ARB_HOLD_LIMIT_EN
      eg = 4'b0001 << ((i / MAXH) % 4);
      ep = (i > 0) && (i % MAXH == 0);
`else
      eg = 4'b0001;
      ep = 1'b0;
`endif
      cycle(4'b1111);
      chk("hold_grant",   8'(bus.grant),   8'(eg));
      chk("hold_preempt", 8'(bus.preempt), 8'(ep));
    end

    // Owner drops at the same edge a timeout would fire: plain release.
    cycle(4'b1101);
    chk("drop_at_limit_pre", 8'(bus.preempt), 8'h00);
    cycle(4'b0000);

    // Asynchronous reset in the middle of an ownership.
    full_reset();
    cycle(4'b0100);
    chk("mid_own2", 8'(bus.grant), 8'h04);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("mid_rst_clear", 8'(bus.grant), 8'h00);
    chk("mid_rst_busy", 8'(bus.bus_busy), 8'h00);
    #2 reset_n = 1'b1;
    model_reset();
    cycle(4'b1100);
    chk("mid_rst_regrant", 8'(bus.grant), 8'h04);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      cycle(4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Round-robin arbiter that shares the single system bus between four masters. It registers one-hot grants that drive the bus master-select mux, and holds a grant while the owner keeps requesting. An optional hold-limit timer forcibly rotates ownership so that no master can starve the others. It replaces the fixed-priority, sticky two-master grant logic when the bus grows to four masters.

## Interface
- MAX_HOLD, 8: maximum consecutive grant cycles for one owner while others wait; legal range 2..255.
- clk  input  1  bus clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  4  per-master bus request; bit i belongs to master i.
- grant  output  4  registered one-hot grant; all-zero when the bus is idle.
- grant_idx  output  2  binary index of the current owner; meaningful only while bus_busy=1.
- bus_busy  output  1  high when any grant bit is set.
- preempt  output  1  one-cycle pulse on the cycle a grant begins after a forced hold-limit rotation.

## Operation
- States:
  - IDLE: grant=0.
  - OWN: exactly one grant bit set.
- Rotation search:
  - Candidate order starts at prio_ptr+1 and wraps mod 4.
  - prio_ptr is internal and equals the index of the last owner.
  - prio_ptr resets to 3, so the first search after reset starts at master 0.
- IDLE -> OWN: if any req bit is sampled high, the first requester in rotation order is granted at that edge.
- OWN, owner req=1, no timeout: grant is unchanged.
- OWN, owner req=0:
  - If other requests are pending, the grant moves at the same edge to the next requester in rotation order, with no idle gap.
  - If no requests are pending, the arbiter goes to IDLE.
- A master that releases and re-requests is ordered last behind the other current requesters.
- Hold counter hold_cnt (8 bits):
  - Cleared to 0 on every new grant.
  - Increments each cycle the same owner keeps the grant.
  - Saturates at MAX_HOLD-1.
- Forced rotation (only with the macro): at an edge where hold_cnt==MAX_HOLD-1, the owner's req=1, and any other req bit=1:
  - The grant moves to the next other requester in rotation order.
  - preempt=1 for the first cycle of the new grant.
- The owner's req is not masked. A preempted master keeps its req high and is re-granted in its turn.
- grant_idx and prio_ptr update together with grant. grant_idx holds its last value in IDLE.
- Simultaneous owner drop and timeout: this is treated as a normal release, and preempt stays 0.

## Timing
- Reset values: grant=0, grant_idx=0, bus_busy=0, preempt=0, state=IDLE, hold_cnt=0, prio_ptr=3.
- Reset is asynchronous. Asserting reset_n mid-ownership clears grant within the same cycle, with no wait for an edge.
- Latency: a req sampled at edge n produces grant valid after edge n. One cycle from a request to its grant from IDLE.
- Handoff latency: zero idle cycles between owners.
- With the macro, the maximum grant length while another master waits is exactly MAX_HOLD cycles.
- All outputs are registered. No combinational path runs from req to grant.

## Configuration
- BUS_ARB_HOLD_LIMIT_EN
  - Defined: hold_cnt and forced rotation are present, and preempt pulses as specified.
  - Undefined: hold_cnt logic is removed, an owner keeps the grant until its req drops, and preempt is tied to 0.

## Test plan
- Reset check:
  - Stimulus: reset_n=0 with req=4'b1111.
  - Required: grant=0, bus_busy=0, grant_idx=0, preempt=0.
  - Then release reset: grant=4'b0001 one cycle later.
- Single request:
  - Stimulus: req=4'b0100 from IDLE.
  - Required: grant=4'b0100, grant_idx=2 and bus_busy=1 after one edge; grant=0 one edge after req drops.
- Zero-gap handoff:
  - Stimulus: owner 0 drops with req=4'b0110.
  - Required: grant=4'b0010 at the next edge, no IDLE cycle; then owner 1 drops and grant=4'b0100.
- Wraparound:
  - Stimulus: owner 3 drops with req=4'b0011.
  - Required: grant=4'b0001, grant_idx=0.
- Hold limit (macro defined, MAX_HOLD=4):
  - Stimulus: req=4'b1111 held constant.
  - Required: the grant sequence is 0,1,2,3,0, each for exactly 4 cycles, with preempt pulsing on the first cycle of each new grant after the first.
  - Without the macro: grant stays 4'b0001 for 40 cycles.
- Reset mid-ownership:
  - Stimulus: owner 2 granted, pulse reset_n low for 3 ns between edges, then req=4'b1100.
  - Required: grant clears immediately; after reset, grant=4'b0100, because the search restarts at master 0.
